// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the iterative multiplier:
//   - state_t : FSM state encoding (IDLE / RUN / DONE)
//   - clog2_f : ceil(log2(value)), used to size the step counter and offset
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_iter_if.sv
// ---------------------------------------------------------------------------
// mult_iter_if
// Request/response bundle of the iterative multiplier.
//   in_valid/in_ready   : operand handshake (a, b, is_signed sampled at accept)
//   out_valid/out_ready : product handshake (z held while out_valid=1)
//   busy                : multiplier is in RUN or DONE
// Modports: master = requester (CPU datapath), slave = multiplier.
// ---------------------------------------------------------------------------
interface mult_iter_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   z;
    logic                 busy;

    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, z, busy
    );

    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, z, busy
    );
endinterface

// File: rtl/mult_step.sv
// ---------------------------------------------------------------------------
// mult_step
// Combinational accumulation of BPC partial products for one iteration.
//   acc      : current 2*WIDTH accumulator
//   mcand    : multiplicand magnitude
//   bits     : the BPC multiplier bits consumed this iteration (LSB first)
//   offset   : bit weight of bits[0]
//   acc_next : acc + sum(bits[i] ? mcand << (offset+i) : 0), modulo 2^(2*WIDTH)
// ---------------------------------------------------------------------------
module mult_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1,
    parameter int OFF_W = 7
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [BPC-1:0]     bits,
    input  logic [OFF_W-1:0]   offset,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [2*WIDTH-1:0] ext_s;
    logic [2*WIDTH-1:0] sum_s;

    assign ext_s = {{WIDTH{1'b0}}, mcand};

    // Add the shifted multiplicand for every set multiplier bit of this step
    always_comb begin
        sum_s = acc;
        for (int i = 0; i < BPC; i++) begin
            if (bits[i]) begin
                sum_s = sum_s + (ext_s << (int'(offset) + i));
            end else begin
                sum_s = sum_s;
            end
        end
    end

    assign acc_next = sum_s;
endmodule

// File: rtl/mult_iter.sv
// ---------------------------------------------------------------------------
// mult_iter
// Iterative signed/unsigned WIDTH x WIDTH -> 2*WIDTH multiplier consuming BPC
// multiplier bits per cycle (STEPS = WIDTH/BPC iterations per product).
// WIDTH must be >= 2 and BPC must divide WIDTH.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low reset (0 = reset)
//   bus   : mult_iter_if slave (in_valid/in_ready, is_signed, a, b,
//           out_valid/out_ready, z, busy)
// Signed operands are converted to magnitudes at accept; the sign of the
// product is re-applied on the final step, so the datapath is unsigned only.
// ---------------------------------------------------------------------------
module mult_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    mult_iter_if.slave bus
);
    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = (clog2_f(STEPS) > 0) ? clog2_f(STEPS) : 1;
    localparam int OFF_W = clog2_f(2 * WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    // Magnitude of an operand; -2^(WIDTH-1) maps exactly onto 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v,
                                                input logic             sgn);
        if (sgn && v[WIDTH-1]) begin
            return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [2*WIDTH-1:0]   z_r;
    logic [2*WIDTH-1:0]   z_neg_s;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [OFF_W-1:0]     offset_s;
    logic                 neg_r;
    logic                 accept_s;
    logic                 last_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic                 in_ready_nxt_s;
    logic                 out_valid_nxt_s;
    logic                 busy_nxt_s;

    // Bit weight of the lowest multiplier bit handled in the current step
    assign offset_s = OFF_W'(int'(cnt_r) * BPC);
    assign z_neg_s  = (~acc_next_s) + {{(2*WIDTH-1){1'b0}}, 1'b1};

    mult_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .OFF_W (OFF_W)
    ) u_step (
        .acc      (acc_r),
        .mcand    (mcand_r),
        .bits     (mplier_r[BPC-1:0]),
        .offset   (offset_s),
        .acc_next (acc_next_s)
    );

    // Next-state logic and next values of the registered handshake outputs
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_s      = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                // Returning to IDLE first means no accept in the release cycle
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        in_ready_nxt_s  = (state_nxt_s == IDLE);
        out_valid_nxt_s = (state_nxt_s == DONE);
        busy_nxt_s      = (state_nxt_s != IDLE);
    end

    // State, handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            mcand_r     <= '0;
            mplier_r    <= '0;
            cnt_r       <= '0;
            neg_r       <= 1'b0;
            z_r         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            if (accept_s) begin
                mcand_r  <= mag_f(bus.a, bus.is_signed);
                mplier_r <= mag_f(bus.b, bus.is_signed);
                neg_r    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                acc_r    <= '0;
                cnt_r    <= '0;
            end else if (state_r == RUN) begin
                acc_r    <= acc_next_s;
                mplier_r <= mplier_r >> BPC;
                cnt_r    <= cnt_r + CNT_W'(1);
                if (last_s) begin
                    z_r <= neg_r ? z_neg_s : acc_next_s;
                end else begin
                    z_r <= z_r;
                end
            end else begin
                acc_r    <= acc_r;
                mplier_r <= mplier_r;
                cnt_r    <= cnt_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.z         = z_r;
endmodule

// File: tb/tb_mult_iter.sv
// ---------------------------------------------------------------------------
// tb_mult_iter
// Scoreboard bench for mult_iter: a default (BPC=1) and a BPC=4 instance.
// Stimulus pushes {expected z, accept cycle} into a queue per instance; a
// monitor per instance checks latency when out_valid rises and z on every
// output transfer.
// ---------------------------------------------------------------------------
module tb_mult_iter;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [63:0] z;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];
    logic pv0 = 1'b0;
    logic pv4 = 1'b0;

    mult_iter_if #(.WIDTH(32)) bus0 ();
    mult_iter_if #(.WIDTH(32)) bus4 ();

    mult_iter #(.WIDTH(32), .BPC(1)) dut  (.clk(clk), .reset(reset), .bus(bus0));
    mult_iter #(.WIDTH(32), .BPC(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor for the BPC=1 instance
    always @(negedge clk) begin
        exp_t e0;
        if (reset && bus0.out_valid && !pv0) begin
            check("pending0", 64'(q0.size()), 64'd1);
            if (q0.size() != 0) check("latency0", 64'(cyc - q0[0].cyc), 64'd32);
        end
        if (reset && bus0.out_valid && bus0.out_ready && q0.size() != 0) begin
            e0 = q0.pop_front();
            check("z0", bus0.z, e0.z);
        end
        pv0 = reset ? bus0.out_valid : 1'b0;
    end

    // Monitor for the BPC=4 instance
    always @(negedge clk) begin
        exp_t e4;
        if (reset && bus4.out_valid && !pv4) begin
            check("pending4", 64'(q4.size()), 64'd1);
            if (q4.size() != 0) check("latency4", 64'(cyc - q4[0].cyc), 64'd8);
        end
        if (reset && bus4.out_valid && bus4.out_ready && q4.size() != 0) begin
            e4 = q4.pop_front();
            check("z4", bus4.z, e4.z);
        end
        pv4 = reset ? bus4.out_valid : 1'b0;
    end

    task automatic issue0(input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic [63:0] ez);
        int n;
        @(posedge clk); #1;
        bus0.a = av; bus0.b = bv; bus0.is_signed = sv; bus0.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus0.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept0", 64'(bus0.in_ready), 64'd1);
        @(posedge clk); #1;
        q0.push_back('{ez, cyc});
        bus0.in_valid = 1'b0;
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while (q0.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain0", 64'(q0.size()), 64'd0);
    endtask

    logic [31:0] va4 [4] = '{32'h12345678, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb4 [4] = '{32'h00000010, 32'h00000005, 32'h00000002, 32'hFFFFFFFF};
    logic        vs4 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] vz4 [4] = '{64'h0000000123456780, 64'h000000000000000F,
                             64'h00000001FFFFFFFE, 64'h0000000000000001};

    initial begin
        int   acc4 [4];
        int   n;
        logic seen;

        bus0.in_valid = 1'b0; bus0.is_signed = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.is_signed = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready0", 64'(bus0.in_ready), 64'd1);
        check("rst_out_valid0", 64'(bus0.out_valid), 64'd0);
        check("rst_z0", bus0.z, 64'd0);
        check("rst_busy0", 64'(bus0.busy), 64'd0);
        check("rst_in_ready4", 64'(bus4.in_ready), 64'd1);
        check("rst_out_valid4", 64'(bus4.out_valid), 64'd0);
        check("rst_z4", bus4.z, 64'd0);
        check("rst_busy4", 64'(bus4.busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed products, default parameters
        issue0(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001); drain0();
        issue0(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000); drain0();
        issue0(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000); drain0();
        issue0(32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFEB); drain0();
        issue0(32'h00000007, 32'hFFFFFFFD, 1'b0, 64'h00000006FFFFFFEB); drain0();

        // Back-pressure: hold the result for 10 cycles
        bus0.out_ready = 1'b0;
        issue0(32'h0000FFFF, 32'h00010001, 1'b0, 64'h00000000FFFFFFFF);
        n = 0;
        @(negedge clk);
        while (!bus0.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_z", bus0.z, 64'h00000000FFFFFFFF);
            check("bp_out_valid", 64'(bus0.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus0.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus0.out_ready = 1'b1;
        bus0.a = 32'd3; bus0.b = 32'd4; bus0.is_signed = 1'b0; bus0.in_valid = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(bus0.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_out_valid", 64'(bus0.out_valid), 64'd0);
        check("bp_idle_in_ready", 64'(bus0.in_ready), 64'd1);
        @(posedge clk); #1;
        q0.push_back('{64'd12, cyc});
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_busy", 64'(bus0.busy), 64'd1);
        drain0();

        // Reset in the middle of a run (counter at 10)
        @(posedge clk); #1;
        bus0.a = 32'd5; bus0.b = 32'd9; bus0.is_signed = 1'b0; bus0.in_valid = 1'b1;
        @(negedge clk);
        check("mid_accept", 64'(bus0.in_ready), 64'd1);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 64'(bus0.busy), 64'd1);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_in_ready", 64'(bus0.in_ready), 64'd1);
        check("mid_out_valid", 64'(bus0.out_valid), 64'd0);
        check("mid_z", bus0.z, 64'd0);
        check("mid_busy_clr", 64'(bus0.busy), 64'd0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus0.out_valid) seen = 1'b1;
        end
        check("mid_no_stale", 64'(seen), 64'd0);

        // BPC=4: back-to-back requests with out_ready held high
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            bus4.a = va4[k]; bus4.b = vb4[k]; bus4.is_signed = vs4[k]; bus4.in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus4.in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("accept4", 64'(bus4.in_ready), 64'd1);
            @(posedge clk); #1;
            q4.push_back('{vz4[k], cyc});
            acc4[k] = cyc;
        end
        bus4.in_valid = 1'b0;
        n = 0;
        while (q4.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain4", 64'(q4.size()), 64'd0);
        for (int k = 1; k < 4; k++) begin
            check("throughput4", 64'(acc4[k] - acc4[k-1]), 64'd10);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
